// File: rtl/adbg_or1k_spr_burst.sv
// Multi-core OR1K SPR bus master: single/burst SPR reads and writes with optional
// write broadcast, streaming data handshakes, per-word ack timeout and error status.
module adbg_or1k_spr_burst #(
  parameter int unsigned NB_CORES       = 4,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      cpu_clk_i,
  input  logic                      cpu_rstn_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [3:0]                req_sel_i,
  input  logic [15:0]               req_addr_i,
  input  logic                      req_wr_i,
  input  logic                      req_bcast_i,
  input  logic [CNT_WIDTH-1:0]      req_count_i,
  input  logic                      wdata_valid_i,
  output logic                      wdata_ready_o,
  input  logic [31:0]               wdata_i,
  output logic                      rdata_valid_o,
  input  logic                      rdata_ready_i,
  output logic [31:0]               rdata_o,
  output logic                      done_o,
  output logic [1:0]                err_o,
  output logic [NB_CORES-1:0][15:0] cpu_addr_o,
  output logic [NB_CORES-1:0][31:0] cpu_data_o,
  input  logic [NB_CORES-1:0][31:0] cpu_data_i,
  output logic [NB_CORES-1:0]       cpu_stb_o,
  output logic [NB_CORES-1:0]       cpu_we_o,
  input  logic [NB_CORES-1:0]       cpu_ack_i
);

  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [4:0]  NB_LIM   = 5'(NB_CORES);

  typedef enum logic [2:0] {IDLE, FETCH, ACCESS, RDRET, DONE} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             sel_q;
  logic [15:0]            addr_q;
  logic                   wr_q, bcast_q;
  logic [CNT_WIDTH-1:0]   remaining_q;
  logic [31:0]            wdata_q;
  logic [NB_CORES-1:0]    ack_mask_q, target, acked;
  logic [TMO_W-1:0]       tmo_q;
  logic [31:0]            rd_word;
  logic [1:0]             req_err;
  logic                   accept, take_wdata, word_done, tmo_hit, step, last, all_acked;

  // Cores addressed by the current command and the selected core's read data
  always_comb begin
    target  = '0;
    rd_word = '0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      target[i] = bcast_q || (sel_q == 4'(i));
      if (sel_q == 4'(i)) rd_word = cpu_data_i[i];
    end
  end

  assign acked     = ack_mask_q | (cpu_ack_i & target);
  assign all_acked = ((acked & target) == target);
  assign last      = (remaining_q == '0);

  always_comb begin
    req_err = 2'b00;
    if (!req_bcast_i && ({1'b0, req_sel_i} >= NB_LIM)) req_err = 2'b01;
    else if (req_bcast_i && !req_wr_i)                 req_err = 2'b11;
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    take_wdata = 1'b0;
    word_done  = 1'b0;
    tmo_hit    = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        accept  = 1'b1;
        state_d = (req_err != 2'b00) ? DONE : (req_wr_i ? FETCH : ACCESS);
      end
      FETCH: if (wdata_valid_i) begin
        take_wdata = 1'b1;
        state_d    = ACCESS;
      end
      // A completing ack beats a timeout landing in the same cycle
      ACCESS: if (all_acked) begin
        word_done = 1'b1;
        if (!wr_q) state_d = RDRET;
        else begin
          step    = 1'b1;
          state_d = last ? DONE : FETCH;
        end
      end else if (TMO_EN && (tmo_q == TMO_W'(TMO_LAST))) begin
        tmo_hit = 1'b1;
        state_d = DONE;
      end
      RDRET: if (rdata_ready_i) begin
        step    = 1'b1;
        state_d = last ? DONE : ACCESS;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      sel_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      bcast_q     <= 1'b0;
      remaining_q <= '0;
      wdata_q     <= '0;
      rdata_o     <= '0;
      err_o       <= 2'b00;
      ack_mask_q  <= '0;
      tmo_q       <= '0;
    end else begin
      if (accept) begin
        sel_q       <= req_sel_i;
        addr_q      <= req_addr_i;
        wr_q        <= req_wr_i;
        bcast_q     <= req_bcast_i;
        remaining_q <= req_count_i;
        err_o       <= req_err;
      end
      if (take_wdata)           wdata_q <= wdata_i;
      if (word_done && !wr_q)   rdata_o <= rd_word;
      if (tmo_hit)              err_o   <= 2'b10;
      if (step && !last) begin
        addr_q      <= addr_q + 16'd1;
        remaining_q <= remaining_q - CNT_WIDTH'(1);
      end
      // Ack mask and timeout counter live only for the duration of one ACCESS visit
      if (state_q == ACCESS) begin
        ack_mask_q <= acked;
        tmo_q      <= tmo_q + TMO_W'(1);
      end else begin
        ack_mask_q <= '0;
        tmo_q      <= '0;
      end
    end
  end

  always_comb begin
    req_ready_o   = (state_q == IDLE);
    wdata_ready_o = (state_q == FETCH);
    rdata_valid_o = (state_q == RDRET);
    done_o        = (state_q == DONE);
    cpu_stb_o     = '0;
    cpu_we_o      = '0;
    cpu_addr_o    = '0;
    cpu_data_o    = '0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      if ((state_q == ACCESS) && target[i] && !ack_mask_q[i]) begin
        cpu_stb_o[i]  = 1'b1;
        cpu_we_o[i]   = wr_q;
        cpu_addr_o[i] = addr_q;
        cpu_data_o[i] = wr_q ? wdata_q : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_adbg_or1k_spr_burst.sv
// Bench for adbg_or1k_spr_burst: transaction-level model plus per-cycle monitor
// against simple latency-programmable SPR core models.
module tb_adbg_or1k_spr_burst;
  localparam int unsigned NB  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned TMO = 8;
  localparam int unsigned QD  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, req_wr, req_bcast;
  logic [3:0] req_sel;
  logic [15:0] req_addr;
  logic [CW-1:0] req_count;
  logic wdata_valid, wdata_ready, rdata_valid, rdata_ready, done;
  logic [31:0] wdata, rdata;
  logic [1:0] err;
  logic [NB-1:0][15:0] cpu_addr;
  logic [NB-1:0][31:0] cpu_wdata, cpu_rdata;
  logic [NB-1:0] stb, we, ack, junk;

  always #5 clk = ~clk;

  adbg_or1k_spr_burst #(.NB_CORES(NB), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .cpu_clk_i(clk), .cpu_rstn_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_sel_i(req_sel),
    .req_addr_i(req_addr), .req_wr_i(req_wr), .req_bcast_i(req_bcast), .req_count_i(req_count),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
    .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
    .done_o(done), .err_o(err),
    .cpu_addr_o(cpu_addr), .cpu_data_o(cpu_wdata), .cpu_data_i(cpu_rdata),
    .cpu_stb_o(stb), .cpu_we_o(we), .cpu_ack_i(ack)
  );

  // Core models: core i acks in the lat[i]-th cycle of a strobe (0 = never)
  int unsigned lat [NB];
  int unsigned run [NB];

  function automatic logic [31:0] rd_pattern(input int c, input logic [15:0] a);
    if (c == 2 && a == 16'h1234) return 32'hCAFEF00D;
    return {4'hA, 4'(c), 8'h5C, a};
  endfunction

  always @(posedge clk)
    for (int i = 0; i < NB; i++) run[i] <= stb[i] ? run[i] + 1 : 0;

  always_comb begin
    ack       = '0;
    cpu_rdata = '0;
    for (int i = 0; i < NB; i++) begin
      ack[i]       = (stb[i] && lat[i] != 0 && run[i] == lat[i] - 1) || junk[i];
      cpu_rdata[i] = rd_pattern(i, cpu_addr[i]);
    end
  end

  // Model state
  logic [15:0] exp_a [NB][QD];
  logic        exp_w [NB][QD];
  logic [31:0] exp_d [NB][QD];
  int unsigned exp_n [NB], got_n [NB];
  logic [31:0] exp_rd [QD];
  int unsigned exp_rd_n, got_rd_n;
  int unsigned exp_stb [NB], mon_stb [NB], base_stb [NB], last_stb [NB];
  int unsigned mon_done_n, n_words, rd_hold;
  logic [1:0]  exp_err;
  logic [NB-1:0] cur_tgt;
  logic        cur_wr;
  logic [31:0] wd [QD];
  logic [15:0] log0 [$];
  int errors, checks;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic monitor();
    logic prev_rd_ack, prev_hold, prev_done;
    logic [31:0] prev_rdata;
    int unsigned k;
    prev_rd_ack = 0; prev_hold = 0; prev_done = 0; prev_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rd_ack = 0; prev_hold = 0; prev_done = 0;
        continue;
      end
      for (int c = 0; c < NB; c++) begin
        if (!cur_tgt[c])
          chk($sformatf("idle_core[%0d]", c), {30'd0, stb[c], we[c]} | 32'(cpu_addr[c]) | cpu_wdata[c], 0);
        if (stb[c]) mon_stb[c]++;
        if (stb[c] && ack[c]) begin
          k = got_n[c];
          if (k >= exp_n[c]) chk($sformatf("unexpected_ack[%0d]", c), 1, 0);
          else begin
            chk($sformatf("acc_addr[%0d]", c), 32'(cpu_addr[c]), 32'(exp_a[c][k]));
            chk($sformatf("acc_we[%0d]", c), 32'(we[c]), 32'(exp_w[c][k]));
            if (exp_w[c][k]) chk($sformatf("acc_data[%0d]", c), cpu_wdata[c], exp_d[c][k]);
            got_n[c]++;
            if (c == 0) log0.push_back(cpu_addr[c]);
          end
        end
      end
      if (prev_rd_ack) chk("rd_latency", 32'(rdata_valid), 1);
      prev_rd_ack = !cur_wr && |(stb & ack & cur_tgt);
      if (prev_hold) chk("rdata_stable", {rdata_valid, rdata[30:0]} ^ {1'b0, rdata[31], 30'd0}, {1'b1, prev_rdata[30:0]} ^ {1'b0, prev_rdata[31], 30'd0});
      if (rdata_valid && rdata_ready) begin
        if (got_rd_n >= exp_rd_n) chk("unexpected_rdata", 1, 0);
        else begin
          chk("rdata", rdata, exp_rd[got_rd_n]);
          got_rd_n++;
        end
      end
      prev_hold  = rdata_valid && !rdata_ready;
      prev_rdata = rdata;
      if (done) begin
        mon_done_n++;
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_single", 32'(prev_done), 0);
      end
      prev_done = done;
    end
  endtask

  task automatic model_cmd(input logic [3:0] sel, input logic [15:0] addr, input logic wr,
                           input logic bcast, input int unsigned count);
    logic tmo;
    logic [15:0] a;
    int unsigned k;
    exp_err = 2'b00;
    if (!bcast && sel >= 4'(NB)) exp_err = 2'b01;
    else if (bcast && !wr)       exp_err = 2'b11;
    cur_tgt = '0;
    if (exp_err == 2'b00) begin
      if (bcast) cur_tgt = '1;
      else       cur_tgt[sel[1:0]] = 1'b1;
    end
    tmo = 1'b0;
    for (int c = 0; c < NB; c++)
      if (cur_tgt[c] && (lat[c] == 0 || lat[c] > TMO)) tmo = 1'b1;
    if (tmo) exp_err = 2'b10;
    n_words = (exp_err == 2'b00) ? count + 1 : (tmo ? 1 : 0);
    cur_wr  = wr;
    for (int c = 0; c < NB; c++) begin
      exp_stb[c]  = 0;
      base_stb[c] = mon_stb[c];
    end
    for (int unsigned w = 0; w < n_words; w++) begin
      a     = addr + 16'(w);
      wd[w] = $urandom;
      for (int c = 0; c < NB; c++) begin
        if (cur_tgt[c]) begin
          if (lat[c] != 0 && lat[c] <= TMO) begin
            k = exp_n[c];
            exp_a[c][k] = a; exp_w[c][k] = wr; exp_d[c][k] = wd[w];
            exp_n[c]++;
            exp_stb[c] += lat[c];
          end else exp_stb[c] += TMO;
        end
      end
      if (!wr && !tmo) begin
        exp_rd[exp_rd_n] = rd_pattern(int'(sel), a);
        exp_rd_n++;
      end
    end
  endtask

  task automatic issue(input logic [3:0] sel, input logic [15:0] addr, input logic wr,
                       input logic bcast, input int unsigned count, output logic ok);
    int cyc;
    req_valid = 1'b1; req_sel = sel; req_addr = addr; req_wr = wr;
    req_bcast = bcast; req_count = CW'(count);
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    ok = (req_ready === 1'b1);
    if (!ok) chk("req_accept", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] sel, input logic [15:0] addr, input logic wr,
                         input logic bcast, input int unsigned count);
    logic ok, fed;
    int cyc;
    int unsigned wi, hold, base_done;
    model_cmd(sel, addr, wr, bcast, count);
    base_done = mon_done_n;
    issue(sel, addr, wr, bcast, count, ok);
    if (!ok) return;
    if (exp_err == 2'b01 || exp_err == 2'b11) chk("err_done_latency", 32'(done), 1);
    else if (wr) chk("wr_fetch_latency", 32'(wdata_ready), 1);
    else         chk("rd_stb_latency", 32'(stb & cur_tgt), 32'(cur_tgt));
    wi = 0; hold = 0; cyc = 0; fed = 1'b0;
    while (done !== 1'b1 && cyc < 500) begin
      wdata_valid = 1'b0; rdata_ready = 1'b0;
      if (wdata_ready && wi < n_words) begin
        wdata_valid = 1'b1; wdata = wd[wi]; wi++; fed = 1'b1;
      end
      if (rdata_valid) begin
        if (hold < rd_hold) hold++;
        else begin rdata_ready = 1'b1; hold = 0; end
      end
      @(posedge clk); #1; cyc++;
      wdata_valid = 1'b0; rdata_ready = 1'b0;
      if (fed) begin
        chk("wr_stb_latency", 32'(stb & cur_tgt), 32'(cur_tgt));
        fed = 1'b0;
      end
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("err_hold", 32'(err), 32'(exp_err));
    chk("done_count", mon_done_n - base_done, 1);
    for (int c = 0; c < NB; c++) begin
      last_stb[c] = mon_stb[c] - base_stb[c];
      chk($sformatf("stb_cycles[%0d]", c), last_stb[c], exp_stb[c]);
      chk($sformatf("acc_left[%0d]", c), got_n[c], exp_n[c]);
    end
    chk("rd_left", got_rd_n, exp_rd_n);
  endtask

  initial begin
    logic ok;
    int cyc;
    logic [15:0] want_a [4];
    int unsigned want_s [NB];
    errors = 0; checks = 0;
    req_valid = 0; req_sel = 0; req_addr = 0; req_wr = 0; req_bcast = 0; req_count = 0;
    wdata_valid = 0; wdata = 0; rdata_ready = 0; junk = '0; rd_hold = 0;
    lat = '{0, 0, 0, 0};
    cur_tgt = '0; cur_wr = 0; exp_err = 2'b00;
    exp_rd_n = 0; got_rd_n = 0; mon_done_n = 0;
    for (int c = 0; c < NB; c++) begin exp_n[c] = 0; got_n[c] = 0; mon_stb[c] = 0; end
    fork monitor(); join_none

    @(posedge clk); #1;
    chk("rst0_req_ready", 32'(req_ready), 1);
    chk("rst0_flags", {26'd0, done, err, rdata_valid, wdata_ready}, 0);
    chk("rst0_bus", 32'({stb, we}), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, core 2 acks in its first strobe cycle
    lat = '{0, 0, 1, 0};
    run_cmd(4'd2, 16'h1234, 1'b0, 1'b0, 0);
    chk("lit_rdata", rdata, 32'hCAFEF00D);
    chk("lit_rd_err", 32'(err), 0);

    // 4-word write across the address wrap, spurious acks on other cores
    lat = '{3, 0, 0, 0}; junk = 4'b1110; log0.delete();
    run_cmd(4'd0, 16'hFFFE, 1'b1, 1'b0, 3);
    junk = '0;
    want_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    chk("lit_wr_words", log0.size(), 4);
    for (int i = 0; i < 4 && i < log0.size(); i++)
      chk($sformatf("lit_wr_addr[%0d]", i), 32'(log0[i]), 32'(want_a[i]));
    chk("lit_wr_err", 32'(err), 0);

    // Broadcast write, staggered acks
    lat = '{1, 4, 2, 7};
    run_cmd(4'd0, 16'h0010, 1'b1, 1'b1, 0);
    want_s = '{1, 4, 2, 7};
    for (int c = 0; c < NB; c++) chk($sformatf("lit_bc_stb[%0d]", c), last_stb[c], want_s[c]);

    // Read timeout: core 1 never acks
    lat = '{0, 0, 0, 0};
    run_cmd(4'd1, 16'h0300, 1'b0, 1'b0, 2);
    chk("lit_tmo_stb", last_stb[1], 8);
    chk("lit_tmo_err", 32'(err), 2);

    // Bad select and broadcast read
    run_cmd(4'd5, 16'h0000, 1'b0, 1'b0, 0);
    chk("lit_sel_err", 32'(err), 1);
    run_cmd(4'd0, 16'h0000, 1'b0, 1'b1, 0);
    chk("lit_bcrd_err", 32'(err), 3);

    // Ack on the last timeout cycle completes; slow consumer
    lat = '{0, 0, 0, 8}; rd_hold = 2;
    run_cmd(4'd3, 16'h7FFF, 1'b0, 1'b0, 1);
    chk("lit_edge_err", 32'(err), 0);

    // Burst read and broadcast write timeout
    lat = '{0, 2, 0, 0}; rd_hold = 1;
    run_cmd(4'd1, 16'h0400, 1'b0, 1'b0, 3);
    lat = '{1, 0, 3, 9}; rd_hold = 0;
    run_cmd(4'd0, 16'h0500, 1'b1, 1'b1, 2);

    // Reset in the middle of a stalled burst read
    lat = '{0, 2, 0, 0};
    model_cmd(4'd1, 16'h0200, 1'b0, 1'b0, 3);
    issue(4'd1, 16'h0200, 1'b0, 1'b0, 3, ok);
    cyc = 0;
    while (rdata_valid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("rst_pre_valid", 32'(rdata_valid), 1);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {26'd0, done, err, rdata_valid, wdata_ready}, 0);
    chk("rst_stb_we", 32'({stb, we}), 0);
    for (int c = 0; c < NB; c++)
      chk($sformatf("rst_bus[%0d]", c), 32'(cpu_addr[c]) | cpu_wdata[c], 0);
    for (int c = 0; c < NB; c++) exp_n[c] = got_n[c];
    exp_rd_n = got_rd_n; cur_tgt = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    lat = '{3, 0, 0, 0};
    run_cmd(4'd0, 16'h0600, 1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
